// File: rtl/adc_avg_pkg.sv
// ---------------------------------------------------------------------------
// adc_avg_pkg : shared FSM encodings and register field positions for adc_avg
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package adc_avg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DONE_BIT    = 31;
    localparam int BUSY_BIT    = 30;
    localparam int RESTART_BIT = 29;
    localparam int TIMEOUT_BIT = 28;

    localparam int NLOG2_LSB = 16;
    localparam int NLOG2_W   = 3;

    localparam int RESULT_W = 12;
    localparam int CNT_W    = 8;

endpackage

`default_nettype wire

// File: rtl/adc_avg_acc.sv
// ---------------------------------------------------------------------------
// adc_avg_acc : sample accumulator, sample counter and optional min/max tracker
// Revision    : 1.0   (min/max tracking enabled by ADC_AVG_MINMAX_EN)
// ---------------------------------------------------------------------------
`default_nettype none

module adc_avg_acc
    import adc_avg_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              clear,
    input  logic              accept,
    input  logic [DW-1:0]     sample_data,
    output logic [DW+6:0]     acc,
    output logic [CNT_W-1:0]  count,
    output logic [31:0]       minmax
);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            acc   <= acc + (DW+7)'(sample_data);
            count <= count + CNT_W'(1);
        end
    end

`ifdef ADC_AVG_MINMAX_EN
    logic [DW-1:0] min_v;
    logic [DW-1:0] max_v;

    // Presetting min to all-ones lets the first sample win both comparisons.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            min_v <= '0;
            max_v <= '0;
        end else if (clear) begin
            min_v <= '1;
            max_v <= '0;
        end else if (accept) begin
            if (sample_data < min_v) min_v <= sample_data;
            if (sample_data > max_v) max_v <= sample_data;
        end
    end

    assign minmax = {4'b0, RESULT_W'(max_v), 4'b0, RESULT_W'(min_v)};
`else
    assign minmax = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/adc_avg.sv
// ---------------------------------------------------------------------------
// adc_avg : PCI-controlled ADC averager (2^N samples) with timeout/status reg
// Revision: 1.0   (optional min/max register via ADC_AVG_MINMAX_EN)
// ---------------------------------------------------------------------------
`default_nettype none

module adc_avg
    import adc_avg_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int DW          = 12
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_data,
    input  logic          valid_pci,
    input  logic          rd_wr,
    input  logic [31:0]   ad_to_tuvv,
    input  logic          avg_sel,
    input  logic          minmax_sel,
    output logic [31:0]   ad_from_tuvv,
    output logic          avg_busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t             state;
    state_t             state_nxt;
    logic [NLOG2_W-1:0] n_log2;
    logic [DW-1:0]      result;
    logic               done_f;
    logic               restart_f;
    logic               timeout_f;
    logic [TW-1:0]      tcnt;

    logic [DW+6:0]      acc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_last;
    logic [31:0]        minmax_word;
    logic [31:0]        status_word;

    logic start, in_run, accept, last, tmo, status_rd, minmax_rd;
    logic unused_wdata;

    assign unused_wdata = ^ad_to_tuvv[30:NLOG2_W];

    assign in_run    = (state == ST_ACC) || (state == ST_DIV);
    assign avg_busy  = in_run;
    assign start     = valid_pci & avg_sel & rd_wr & ad_to_tuvv[31];
    assign status_rd = valid_pci & avg_sel & ~rd_wr;
    assign minmax_rd = valid_pci & minmax_sel & ~avg_sel & ~rd_wr;

    assign accept     = (state == ST_ACC) & sample_valid & ~start;
    assign count_last = (CNT_W'(1) << n_log2) - CNT_W'(1);
    assign last       = accept & (count == count_last);
    assign tmo        = (state == ST_ACC) & ~sample_valid & (tcnt == TW'(TIMEOUT_CYC - 1));

    adc_avg_acc #(.DW(DW)) u_acc (
        .clk         (clk),
        .rst_        (rst_),
        .clear       (start),
        .accept      (accept),
        .sample_data (sample_data),
        .acc         (acc),
        .count       (count),
        .minmax      (minmax_word)
    );

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_ACC;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_IDLE;
                ST_ACC: begin
                    if (last)     state_nxt = ST_DIV;
                    else if (tmo) state_nxt = ST_DONE;
                end
                ST_DIV:  state_nxt = ST_DONE;
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        status_word                              = '0;
        status_word[DONE_BIT]                    = done_f;
        status_word[BUSY_BIT]                    = in_run;
        status_word[RESTART_BIT]                 = restart_f;
        status_word[TIMEOUT_BIT]                 = timeout_f;
        status_word[NLOG2_LSB +: NLOG2_W]        = n_log2;
        status_word[RESULT_W-1:0]                = RESULT_W'(result);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            n_log2       <= '0;
            result       <= '0;
            done_f       <= 1'b0;
            restart_f    <= 1'b0;
            timeout_f    <= 1'b0;
            tcnt         <= '0;
            ad_from_tuvv <= '0;
        end else begin
            if (start) n_log2 <= ad_to_tuvv[NLOG2_W-1:0];

            if (!start && state == ST_DIV) result <= DW'(acc >> n_log2);
            else if (!start && tmo)        result <= '0;

            if (start || accept)     tcnt <= '0;
            else if (state == ST_ACC) tcnt <= tcnt + TW'(1);

            // Flags set by this cycle's events override a clearing status read.
            if (start) begin
                done_f    <= 1'b0;
                restart_f <= in_run;
                timeout_f <= 1'b0;
            end else begin
                if (status_rd) begin
                    done_f    <= 1'b0;
                    restart_f <= 1'b0;
                    timeout_f <= 1'b0;
                end
                if (state == ST_DONE) done_f    <= 1'b1;
                if (tmo)              timeout_f <= 1'b1;
            end

            if (status_rd)      ad_from_tuvv <= status_word;
            else if (minmax_rd) ad_from_tuvv <= minmax_word;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adc_avg.sv
// ---------------------------------------------------------------------------
// tb_adc_avg : scoreboard testbench for adc_avg (optionally ADC_AVG_MINMAX_EN)
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_adc_avg;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          valid_pci;
    logic          rd_wr;
    logic [31:0]   ad_to_tuvv;
    logic          avg_sel;
    logic          minmax_sel;
    logic [31:0]   ad_from_tuvv;
    logic          avg_busy;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_q = 1'b0;

    always #5 clk = ~clk;

    adc_avg #(.TIMEOUT_CYC(16), .DW(DW)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .valid_pci    (valid_pci),
        .rd_wr        (rd_wr),
        .ad_to_tuvv   (ad_to_tuvv),
        .avg_sel      (avg_sel),
        .minmax_sel   (minmax_sel),
        .ad_from_tuvv (ad_from_tuvv),
        .avg_busy     (avg_busy)
    );

    // Read data appears one cycle after the decoded read; compare at the next negedge.
    always @(posedge clk) rd_q <= valid_pci && (avg_sel || minmax_sel) && !rd_wr;

    always @(negedge clk) begin
        if (rd_q) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got %08h, no expected value queued", ad_from_tuvv);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (ad_from_tuvv !== e) begin
                    errors++;
                    $display("FAIL %s: got %08h, expected %08h", nm, ad_from_tuvv, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] d);
        valid_pci  = 1'b1;
        avg_sel    = 1'b1;
        rd_wr      = 1'b1;
        ad_to_tuvv = d;
        tick();
        valid_pci  = 1'b0;
        avg_sel    = 1'b0;
        rd_wr      = 1'b0;
        ad_to_tuvv = '0;
    endtask

    task automatic start(input logic [2:0] n);
        wr({1'b1, 28'b0, n});
    endtask

    task automatic feed(input logic [DW-1:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
        sample_data  = '0;
    endtask

    task automatic rd(input logic use_avg, input logic use_mm, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        valid_pci  = 1'b1;
        avg_sel    = use_avg;
        minmax_sel = use_mm;
        rd_wr      = 1'b0;
        tick();
        valid_pci  = 1'b0;
        avg_sel    = 1'b0;
        minmax_sel = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (avg_busy && n < 200) begin
            tick();
            n++;
        end
        if (avg_busy) begin
            vectors++;
            errors++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", nm, n);
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_         = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        valid_pci    = 1'b0;
        rd_wr        = 1'b0;
        ad_to_tuvv   = '0;
        avg_sel      = 1'b0;
        minmax_sel   = 1'b0;
        tick();
        tick();
        check("reset_rdata", ad_from_tuvv, 32'h0);
        check("reset_busy", {31'b0, avg_busy}, 32'h0);
        rst_ = 1'b1;
        tick();

        // Basic 4-sample average
        start(3'd2);
        check("acc_busy", {31'b0, avg_busy}, 32'h1);
        feed(12'd100); feed(12'd200); feed(12'd300); feed(12'd400);
        wait_done("avg4_wait");
        rd(1'b1, 1'b0, 32'h800200FA, "avg4_status");
        wr(32'h0000_0005);
        rd(1'b1, 1'b0, 32'h000200FA, "nostart_write");
        rd(1'b1, 1'b1, 32'h000200FA, "both_sel_avg_wins");
        tick(); tick(); tick();
        check("rdata_hold", ad_from_tuvv, 32'h000200FA);

        // Single sample, full-scale code
        start(3'd0);
        feed(12'hFFF);
        wait_done("one_wait");
        rd(1'b1, 1'b0, 32'h80000FFF, "one_status");
        rd(1'b1, 1'b0, 32'h00000FFF, "one_status_cleared");

        // Timeout after two samples
        start(3'd3);
        feed(12'd50); feed(12'd60);
        check("tmo_busy", {31'b0, avg_busy}, 32'h1);
        wait_done("tmo_wait");
        rd(1'b1, 1'b0, 32'h90030000, "timeout_status");

        // Restart mid-acquisition
        start(3'd7);
        for (int i = 0; i < 10; i++) feed(12'(i * 37 + 1));
        start(3'd1);
        check("restart_busy", {31'b0, avg_busy}, 32'h1);
        feed(12'd5); feed(12'd7);
        wait_done("restart_wait");
        rd(1'b1, 1'b0, 32'hA0010006, "restart_status");

        // Asynchronous reset during ACC
        start(3'd2);
        feed(12'd123);
        rst_ = 1'b0;
        #2;
        check("async_rst_busy", {31'b0, avg_busy}, 32'h0);
        check("async_rst_rdata", ad_from_tuvv, 32'h0);
        tick();
        rst_ = 1'b1;
        tick();
        feed(12'd1); feed(12'd2); feed(12'd3); feed(12'd4);
        check("post_rst_busy", {31'b0, avg_busy}, 32'h0);
        rd(1'b1, 1'b0, 32'h00000000, "post_rst_status");

        // Min/max acquisition
        start(3'd2);
        feed(12'd10); feed(12'd4000); feed(12'd7); feed(12'd9);
        wait_done("mm_wait");
        rd(1'b1, 1'b0, 32'h800203EE, "mm_avg_status");
`ifdef ADC_AVG_MINMAX_EN
        rd(1'b0, 1'b1, 32'h0FA00007, "minmax_read");
`else
        rd(1'b0, 1'b1, 32'h00000000, "minmax_read");
`endif

        tick(); tick(); tick();
        if (exp_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL pending_reads: got %0d unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
